// File: rtl/seq_alu.sv
// Clocked ALU with registered results and a start/done handshake.
// MUL (shift-add) and DIVU (restoring) iterate one bit per cycle.
module seq_alu #(
  parameter int WIDTH     = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rslt,
  output logic [WIDTH-1:0] rslt_hi,
  output logic             zero,
  output logic             carry,
  output logic             div_zero,
  output logic             illegal,
  output logic             dbg_state
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [AW-1:0]    CNT_LAST = AW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_ROTL = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_PAR  = 4'd9;
  localparam logic [3:0] OP_MOV  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Handshake: start is sampled on a rising edge only while busy=0; that edge
  // latches op/in_a/in_b. done is a one-cycle pulse marking the cycle in which
  // rslt/rslt_hi/flags first show the new result; they then hold until the
  // next accepted op completes. A start during the done cycle is accepted.

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rslt_q, rslt_d;
  logic [WIDTH-1:0] rslt_hi_q, rslt_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             div_zero_q, div_zero_d;
  logic             illegal_q, illegal_d;

  // Single-cycle result path
  logic [WIDTH:0]     add_full;
  logic [2*WIDTH-1:0] rot_full;
  logic [WIDTH-1:0]   sc_rslt;
  logic               sc_carry;
  logic               op_muldiv;
  logic               sc_illegal;

  always_comb begin
    add_full   = {1'b0, in_a} + {1'b0, in_b};
    rot_full   = {in_a, in_a} << in_b[AW-1:0];
    op_muldiv  = (op == OP_MUL) || (op == OP_DIVU);
    sc_illegal = (op > OP_DIVU) || (op_muldiv && !MULDIV_EN);
    sc_rslt    = '0;
    sc_carry   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_rslt  = add_full[WIDTH-1:0];
        sc_carry = add_full[WIDTH];
      end
      OP_SUB: begin
        sc_rslt  = in_a - in_b;
        sc_carry = in_a < in_b;
      end
      OP_AND:  sc_rslt = in_a & in_b;
      OP_OR:   sc_rslt = in_a | in_b;
      OP_XOR:  sc_rslt = in_a ^ in_b;
      OP_SHL:  sc_rslt = (in_b >= W_LIM) ? '0 : (in_a << in_b);
      OP_SHR:  sc_rslt = (in_b >= W_LIM) ? '0 : (in_a >> in_b);
      OP_ROTL: sc_rslt = rot_full[2*WIDTH-1:WIDTH];
      OP_SLT:  sc_rslt = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_PAR:  sc_rslt = {{(WIDTH-1){1'b0}}, ^in_a};
      OP_MOV:  sc_rslt = in_b;
      default: sc_rslt = '0;
    endcase
  end

  // One iteration step: hi_q:lo_q is the partial product, or remainder:dividend
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_tmp;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_tmp = {hi_q, lo_q[WIDTH-1]};
    div_sub = div_tmp - {1'b0, opb_q};
    div_ge  = div_tmp >= {1'b0, opb_q};
    if (is_div_q) begin
      step_hi = div_ge ? div_sub[WIDTH-1:0] : div_tmp[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    done_d     = 1'b0;
    rslt_d     = rslt_q;
    rslt_hi_d  = rslt_hi_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    div_zero_d = div_zero_q;
    illegal_d  = illegal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_muldiv && MULDIV_EN) begin
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = (op == OP_DIVU);
            hi_d     = '0;
            lo_d     = in_a;
            opb_d    = in_b;
          end else begin
            done_d     = 1'b1;
            rslt_d     = sc_rslt;
            rslt_hi_d  = '0;
            zero_d     = (sc_rslt == '0);
            carry_d    = sc_carry;
            div_zero_d = 1'b0;
            illegal_d  = sc_illegal;
          end
        end
      end
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          done_d     = 1'b1;
          rslt_d     = step_lo;
          rslt_hi_d  = step_hi;
          zero_d     = is_div_q ? (step_lo == '0) : ((step_lo == '0) && (step_hi == '0));
          carry_d    = 1'b0;
          div_zero_d = is_div_q && (opb_q == '0);
          illegal_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      done_q     <= 1'b0;
      rslt_q     <= '0;
      rslt_hi_q  <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      done_q     <= done_d;
      rslt_q     <= rslt_d;
      rslt_hi_q  <= rslt_hi_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign rslt      = rslt_q;
  assign rslt_hi   = rslt_hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign div_zero  = div_zero_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

endmodule
